vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Upstream pixel source for the 640x480 VGA timing driver, clocked on vga_clk.
- Reads a double-buffered 320x240 RGB444 frame buffer held in BRAM.
- Upscales 2x in each direction: every source pixel is shown twice per line, and every source line is shown on two display lines.
- Prefetches from the driver's pre3 valid window so that rgb_data lines up with the driver's active window. Swaps buffer banks only at frame boundaries, under a ready/swap handshake with the camera-side writer.

Parameters:
- SRC_W, 320, source pixels per line
- SRC_H, 240, source lines per frame
- ADDR_W, 17, BRAM address width; ceil(log2(SRC_W*SRC_H))

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vga_valid_pre3  in  1  active window advanced 3 clocks, from the VGA driver
- vsync_r_pos  in  1  one-cycle pulse at the start of each frame's vertical sync, from the VGA driver
- frame_ready  in  1  one-cycle pulse from the writer: back bank is complete
- fb_rd_en  out  1  BRAM read enable
- fb_rd_addr  out  ADDR_W  BRAM read address within the bank
- fb_rd_data  in  12  BRAM read data, RGB444, 1-cycle read latency
- fb_bank_sel  out  1  bank currently displayed; the writer uses the other bank
- frame_swap  out  1  one-cycle pulse when the banks swap
- rgb_data  out  12  pixel to the VGA driver

Behaviour:
- Reset values: every output 0; all counters 0; swap pending cleared.
- Pipeline, with T = a cycle in which vga_valid_pre3 is sampled high:
  - T+1: fb_rd_en=1, fb_rd_addr registered.
  - T+2: fb_rd_data valid.
  - T+3: rgb_data <= fb_rd_data.
  - Total 3 clocks, so rgb_data aligns exactly with the driver's active window.
- Valid delay: rgb_data is forced to 0 on any cycle whose T-3 sample of pre3 was low. Implement with a 2-deep delay of rd_en.
- Address generation, driven by registered counters x_sub (1b), src_x, y_sub (1b), line_base:
  - fb_rd_addr = line_base + src_x.
  - Each pre3-high cycle: x_sub toggles; when x_sub was 1, src_x increments.
  - Each source address is therefore issued on two consecutive cycles.
- End of line, detected as a pre3 falling edge (pre3_d & ~pre3):
  - src_x=0, x_sub=0, and y_sub toggles.
  - If y_sub was 1, line_base += SRC_W.
- Saturation: src_x never exceeds SRC_W-1. line_base saturates at (SRC_H-1)*SRC_W, so extra active lines repeat the last source line.
- vsync_r_pos: clears src_x, x_sub, y_sub and line_base. This has priority over any same-cycle counter update.
- Frame handshake:
  - frame_ready sets swap_pending.
  - On vsync_r_pos with swap_pending (or frame_ready in the same cycle): fb_bank_sel toggles, frame_swap=1 for one cycle, swap_pending clears.
  - Multiple frame_ready pulses within one frame collapse into a single swap.
  - No swap ever occurs away from vsync_r_pos.
- Mid-operation reset: all state returns to reset values immediately. Output restarts on the next pre3 window. Counters are only guaranteed correct after the next vsync_r_pos.
- Widths: line_base and the address sum are ADDR_W wide. No wrap is possible inside the legal range.

Optional Feature:
- Macro: VGA_FRAME_READER_BBOX_EN.
- When defined:
  - Extra inputs bbox_x0/x1 (9b, source coords), bbox_y0/y1 (8b), bbox_en.
  - These are latched on vsync_r_pos, so they stay stable for the whole frame.
  - At stage T+3, if bbox_en and the source pixel lies on the box edge (x in {x0,x1} with y0<=y<=y1, or y in {y0,y1} with x0<=x<=x1), rgb_data = 12'hF00 instead of pixel data.
  - src_x and src_y are delayed alongside the pipeline for this comparison.
- When undefined: no extra ports or logic.

Decomposition:
- Shared package vga_pkg holds:
  - SRC_W, SRC_H, ADDR_W constants
  - the RGB444 typedef (12 bits)
  - the bbox colour constant
- One natural sub-module: vga_addr_gen, containing the counters and line_base. The pipeline, handshake and overlay stay in the top module.

Test Plan:
- First active line after reset + vsync_r_pos → fb_rd_addr sequence 0,0,1,1,…,319,319 over 640 pre3 cycles; rgb_data first nonzero exactly 3 clocks after pre3 rises.
- Display lines 0,1 → line_base 0; lines 2,3 → 320; line 479 → line_base 76480, last address 76799.
- frame_ready mid-frame → no toggle until the next vsync_r_pos; then fb_bank_sel 0→1 with a one-cycle frame_swap. Two frame_ready pulses in one frame → exactly one swap.
- frame_ready in the same cycle as vsync_r_pos → swap happens that cycle.
- rst_n pulsed low mid-line → all outputs 0 asynchronously; after release plus vsync_r_pos, the address sequence restarts at 0.
- With VGA_FRAME_READER_BBOX_EN, box (10,10)-(20,20) → display pixels x=20,21 on y=20..41 output 12'hF00; interior pixels pass BRAM data unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the VGA frame reader
package vga_pkg;

   localparam int SRC_W  = 320;
   localparam int SRC_H  = 240;
   localparam int ADDR_W = 17;

   typedef logic [11:0] rgb444_t;

   localparam rgb444_t BBOX_COLOR = 12'hF00;

endpackage

// File: rtl/vga_addr_gen.sv
// rtl/vga_addr_gen.sv - source address counters for the 2x upscaled frame scan
// Source coordinate outputs exist only with VGA_FRAME_READER_BBOX_EN
module vga_addr_gen #(
   parameter int SRC_W  = vga_pkg::SRC_W,
   parameter int SRC_H  = vga_pkg::SRC_H,
   parameter int ADDR_W = vga_pkg::ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pre3,
   input  logic                       vsync,
   output logic [ADDR_W-1:0]          addr
`ifdef VGA_FRAME_READER_BBOX_EN
   ,
   output logic [$clog2(SRC_W)-1:0]   src_x,
   output logic [$clog2(SRC_H)-1:0]   src_y
`endif
);

   localparam int XW = $clog2(SRC_W);
   localparam logic [XW-1:0]     X_MAX   = XW'(SRC_W - 1);
   localparam logic [ADDR_W-1:0] LB_MAX  = ADDR_W'((SRC_H - 1) * SRC_W);
   localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(SRC_W);

   logic              pre3_d_q, pre3_d_d;
   logic              x_sub_q, x_sub_d;
   logic              y_sub_q, y_sub_d;
   logic [XW-1:0]     src_x_q, src_x_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;

   // vsync wins over both the per-pixel step and the end-of-line step
   always_comb begin
      pre3_d_d    = pre3;
      x_sub_d     = x_sub_q;
      y_sub_d     = y_sub_q;
      src_x_d     = src_x_q;
      line_base_d = line_base_q;
      if (vsync) begin
         x_sub_d     = 1'b0;
         y_sub_d     = 1'b0;
         src_x_d     = '0;
         line_base_d = '0;
      end else if (pre3) begin
         x_sub_d = ~x_sub_q;
         if (x_sub_q && (src_x_q != X_MAX)) src_x_d = src_x_q + 1'b1;
      end else if (pre3_d_q) begin
         x_sub_d = 1'b0;
         src_x_d = '0;
         y_sub_d = ~y_sub_q;
         if (y_sub_q && (line_base_q != LB_MAX)) line_base_d = line_base_q + LB_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre3_d_q    <= 1'b0;
         x_sub_q     <= 1'b0;
         y_sub_q     <= 1'b0;
         src_x_q     <= '0;
         line_base_q <= '0;
      end else begin
         pre3_d_q    <= pre3_d_d;
         x_sub_q     <= x_sub_d;
         y_sub_q     <= y_sub_d;
         src_x_q     <= src_x_d;
         line_base_q <= line_base_d;
      end
   end

   assign addr = line_base_q + ADDR_W'(src_x_q);

`ifdef VGA_FRAME_READER_BBOX_EN
   localparam int YW = $clog2(SRC_H);
   localparam logic [YW-1:0] Y_MAX = YW'(SRC_H - 1);

   logic [YW-1:0] src_y_q, src_y_d;

   // src_y tracks line_base / SRC_W so the overlay avoids a divider
   always_comb begin
      src_y_d = src_y_q;
      if (vsync) src_y_d = '0;
      else if (!pre3 && pre3_d_q && y_sub_q && (src_y_q != Y_MAX)) src_y_d = src_y_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) src_y_q <= '0;
      else        src_y_q <= src_y_d;
   end

   assign src_x = src_x_q;
   assign src_y = src_y_q;
`endif

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - double-buffered 320x240 frame reader with 2x upscale for 640x480 VGA
// Optional bounding-box overlay: VGA_FRAME_READER_BBOX_EN
module vga_frame_reader #(
   parameter int SRC_W  = vga_pkg::SRC_W,
   parameter int SRC_H  = vga_pkg::SRC_H,
   parameter int ADDR_W = vga_pkg::ADDR_W
) (
   input  logic                       vga_clk,
   input  logic                       rst_n,
   input  logic                       vga_valid_pre3,
   input  logic                       vsync_r_pos,
   input  logic                       frame_ready,
   output logic                       fb_rd_en,
   output logic [ADDR_W-1:0]          fb_rd_addr,
   input  vga_pkg::rgb444_t           fb_rd_data,
   output logic                       fb_bank_sel,
   output logic                       frame_swap,
   output vga_pkg::rgb444_t           rgb_data
`ifdef VGA_FRAME_READER_BBOX_EN
   ,
   input  logic [$clog2(SRC_W)-1:0]   bbox_x0,
   input  logic [$clog2(SRC_W)-1:0]   bbox_x1,
   input  logic [$clog2(SRC_H)-1:0]   bbox_y0,
   input  logic [$clog2(SRC_H)-1:0]   bbox_y1,
   input  logic                       bbox_en
`endif
);

   import vga_pkg::*;

   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, gen_addr;
   logic              en_p2_q, en_p2_d;
   rgb444_t           rgb_q, rgb_d;
   logic              bank_q, bank_d;
   logic              swap_q, swap_d;
   logic              pend_q, pend_d;
   logic              box_hit;

`ifdef VGA_FRAME_READER_BBOX_EN
   localparam int XW = $clog2(SRC_W);
   localparam int YW = $clog2(SRC_H);

   logic [XW-1:0] gen_x, x_p1_q, x_p2_q, bx0_q, bx1_q;
   logic [YW-1:0] gen_y, y_p1_q, y_p2_q, by0_q, by1_q;
   logic          ben_q;

   vga_addr_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) u_addr_gen (
      .clk   (vga_clk),
      .rst_n (rst_n),
      .pre3  (vga_valid_pre3),
      .vsync (vsync_r_pos),
      .addr  (gen_addr),
      .src_x (gen_x),
      .src_y (gen_y)
   );

   // Coordinates ride two stages behind the address so they meet fb_rd_data
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         x_p1_q <= '0;
         x_p2_q <= '0;
         y_p1_q <= '0;
         y_p2_q <= '0;
         bx0_q  <= '0;
         bx1_q  <= '0;
         by0_q  <= '0;
         by1_q  <= '0;
         ben_q  <= 1'b0;
      end else begin
         x_p1_q <= gen_x;
         x_p2_q <= x_p1_q;
         y_p1_q <= gen_y;
         y_p2_q <= y_p1_q;
         if (vsync_r_pos) begin
            bx0_q <= bbox_x0;
            bx1_q <= bbox_x1;
            by0_q <= bbox_y0;
            by1_q <= bbox_y1;
            ben_q <= bbox_en;
         end
      end
   end

   assign box_hit = en_p2_q && ben_q &&
      ((((x_p2_q == bx0_q) || (x_p2_q == bx1_q)) && (y_p2_q >= by0_q) && (y_p2_q <= by1_q)) ||
       (((y_p2_q == by0_q) || (y_p2_q == by1_q)) && (x_p2_q >= bx0_q) && (x_p2_q <= bx1_q)));
`else
   vga_addr_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) u_addr_gen (
      .clk   (vga_clk),
      .rst_n (rst_n),
      .pre3  (vga_valid_pre3),
      .vsync (vsync_r_pos),
      .addr  (gen_addr)
   );

   assign box_hit = 1'b0;
`endif

   always_comb begin
      rd_en_d   = vga_valid_pre3;
      rd_addr_d = vga_valid_pre3 ? gen_addr : rd_addr_q;
      en_p2_d   = rd_en_q;
      rgb_d     = en_p2_q ? fb_rd_data : '0;
      if (box_hit) rgb_d = BBOX_COLOR;
      bank_d = bank_q;
      swap_d = 1'b0;
      pend_d = pend_q | frame_ready;
      // A ready arriving with vsync still swaps this frame
      if (vsync_r_pos) begin
         pend_d = 1'b0;
         if (pend_q || frame_ready) begin
            bank_d = ~bank_q;
            swap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         en_p2_q   <= 1'b0;
         rgb_q     <= '0;
         bank_q    <= 1'b0;
         swap_q    <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         en_p2_q   <= en_p2_d;
         rgb_q     <= rgb_d;
         bank_q    <= bank_d;
         swap_q    <= swap_d;
         pend_q    <= pend_d;
      end
   end

   assign fb_rd_en    = rd_en_q;
   assign fb_rd_addr  = rd_addr_q;
   assign fb_bank_sel = bank_q;
   assign frame_swap  = swap_q;
   assign rgb_data    = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader against a frame-level model
module tb_vga_frame_reader;

   logic        vga_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pre3 = 1'b0;
   logic        vsync = 1'b0;
   logic        fr = 1'b0;
   logic        fb_rd_en;
   logic [16:0] fb_rd_addr;
   logic [11:0] fb_rd_data;
   logic        fb_bank_sel;
   logic        frame_swap;
   logic [11:0] rgb_data;

   vga_frame_reader dut (
      .vga_clk        (vga_clk),
      .rst_n          (rst_n),
      .vga_valid_pre3 (pre3),
      .vsync_r_pos    (vsync),
      .frame_ready    (fr),
      .fb_rd_en       (fb_rd_en),
      .fb_rd_addr     (fb_rd_addr),
      .fb_rd_data     (fb_rd_data),
      .fb_bank_sel    (fb_bank_sel),
      .frame_swap     (frame_swap),
      .rgb_data       (rgb_data)
   );

   always #5 vga_clk = ~vga_clk;

   logic [11:0] mem [0:76799];
   always @(posedge vga_clk) if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model: display line / pixel since vsync, scoreboard of the last 3 issued cycles
   int m_dl, m_px;
   bit m_prev, m_bank, m_pend, m_swap;
   bit h_en [1:3];
   int h_addr [1:3];

   task automatic model_reset();
      m_dl = 0; m_px = 0; m_prev = 0; m_bank = 0; m_pend = 0; m_swap = 0;
      for (int i = 1; i <= 3; i++) begin h_en[i] = 0; h_addr[i] = 0; end
   endtask

   task automatic tick(input bit p, input bit v, input bit f);
      int a;
      int sy, sx;
      logic [11:0] er;
      pre3 = p; vsync = v; fr = f;
      sy = (m_dl / 2 > 239) ? 239 : m_dl / 2;
      sx = (m_px / 2 > 319) ? 319 : m_px / 2;
      a = sy * 320 + sx;
      if (v) begin m_dl = 0; m_px = 0; end
      else if (p) m_px++;
      else if (m_prev) begin m_dl++; m_px = 0; end
      m_prev = p;
      m_swap = v && (m_pend || f);
      if (m_swap) m_bank = ~m_bank;
      m_pend = v ? 1'b0 : (m_pend | f);
      h_en[3] = h_en[2]; h_addr[3] = h_addr[2];
      h_en[2] = h_en[1]; h_addr[2] = h_addr[1];
      h_en[1] = p;       h_addr[1] = a;
      @(posedge vga_clk); #1;
      cyc++;
      tests++;
      if (fb_rd_en !== h_en[1]) begin
         fails++; $display("FAIL rd_en cyc=%0d got %0b want %0b", cyc, fb_rd_en, h_en[1]);
      end
      if (h_en[1]) begin
         tests++;
         if (fb_rd_addr !== 17'(h_addr[1])) begin
            fails++; $display("FAIL rd_addr cyc=%0d got %0d want %0d", cyc, fb_rd_addr, h_addr[1]);
         end
      end
      er = h_en[3] ? mem[h_addr[3]] : 12'h000;
      tests++;
      if (rgb_data !== er) begin
         fails++; $display("FAIL rgb cyc=%0d got %03h want %03h", cyc, rgb_data, er);
      end
      tests++;
      if (fb_bank_sel !== m_bank || frame_swap !== m_swap) begin
         fails++; $display("FAIL bank/swap cyc=%0d got %0b/%0b want %0b/%0b",
                           cyc, fb_bank_sel, frame_swap, m_bank, m_swap);
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0);
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) tick(1, 0, 0);
   endtask

   task automatic check_idle(input string tag);
      tests++;
      if ({fb_rd_en, fb_rd_addr, fb_bank_sel, frame_swap, rgb_data} !== '0) begin
         fails++;
         $display("FAIL %s outputs en=%0b addr=%0d bank=%0b swap=%0b rgb=%03h want all 0",
                  tag, fb_rd_en, fb_rd_addr, fb_bank_sel, frame_swap, rgb_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      check_idle("reset");
      @(posedge vga_clk); @(posedge vga_clk); #3;
      check_idle("reset_held");
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_first_line();
      tick(0, 1, 0);
      gap(3);
      for (int k = 0; k < 640; k++) begin
         tick(1, 0, 0);
         tests++;
         if (fb_rd_addr !== 17'(k / 2)) begin
            fails++; $display("FAIL first_line_addr k=%0d got %0d want %0d", k, fb_rd_addr, k / 2);
         end
         if (k < 2) begin
            tests++;
            if (rgb_data !== 12'h000) begin
               fails++; $display("FAIL early_rgb k=%0d got %03h want 000", k, rgb_data);
            end
         end else if (k == 2) begin
            tests++;
            if (rgb_data !== mem[0]) begin
               fails++; $display("FAIL first_rgb got %03h want %03h", rgb_data, mem[0]);
            end
         end
      end
      gap(6);
   endtask

   task automatic test_full_frame();
      tick(0, 1, 0);
      gap(4);
      for (int l = 0; l < 482; l++) begin
         int n;
         n = (l < 4 || l >= 478) ? 640 : int'($urandom_range(1, 6));
         if (l == 481) n = 660;
         tick(1, 0, 0);
         if (l == 1 || l == 2 || l == 3) begin
            tests++;
            if (fb_rd_addr !== ((l < 2) ? 17'd0 : 17'd320)) begin
               fails++; $display("FAIL line_base line=%0d got %0d", l, fb_rd_addr);
            end
         end
         pixels(n - 1);
         if (l >= 479) begin
            tests++;
            if (fb_rd_addr !== 17'd76799) begin
               fails++; $display("FAIL last_addr line=%0d got %0d want 76799", l, fb_rd_addr);
            end
         end
         gap(4);
      end
   endtask

   task automatic test_swap();
      bit b0;
      int swaps;
      tick(0, 1, 0);
      gap(2);
      pixels(8);
      b0 = m_bank;
      tick(0, 0, 1);
      gap(5);
      tests++;
      if (fb_bank_sel !== b0 || frame_swap !== 1'b0) begin
         fails++; $display("FAIL early_swap got bank=%0b swap=%0b want bank=%0b swap=0", fb_bank_sel, frame_swap, b0);
      end
      tick(0, 1, 0);
      tests++;
      if (fb_bank_sel !== ~b0 || frame_swap !== 1'b1) begin
         fails++; $display("FAIL vsync_swap got bank=%0b swap=%0b want bank=%0b swap=1", fb_bank_sel, frame_swap, ~b0);
      end
      tick(0, 0, 0);
      tests++;
      if (frame_swap !== 1'b0) begin
         fails++; $display("FAIL swap_width got %0b want 0", frame_swap);
      end
      swaps = 0;
      tick(0, 0, 1); swaps += frame_swap;
      for (int i = 0; i < 4; i++) begin tick(0, 0, 0); swaps += frame_swap; end
      tick(0, 0, 1); swaps += frame_swap;
      for (int i = 0; i < 4; i++) begin tick(0, 0, 0); swaps += frame_swap; end
      tick(0, 1, 0); swaps += frame_swap;
      for (int i = 0; i < 4; i++) begin tick(0, 0, 0); swaps += frame_swap; end
      tick(0, 1, 0); swaps += frame_swap;
      tests++;
      if (swaps != 1) begin
         fails++; $display("FAIL double_ready_swaps got %0d want 1", swaps);
      end
   endtask

   task automatic test_swap_same_cycle();
      bit b0;
      gap(3);
      b0 = m_bank;
      tick(0, 1, 1);
      tests++;
      if (fb_bank_sel !== ~b0 || frame_swap !== 1'b1) begin
         fails++; $display("FAIL same_cycle_swap got bank=%0b swap=%0b want bank=%0b swap=1", fb_bank_sel, frame_swap, ~b0);
      end
      gap(3);
   endtask

   task automatic test_reset_midline();
      tick(0, 1, 0);
      gap(2);
      pixels(100);
      #2 rst_n = 1'b0;
      pre3 = 1'b0;
      #1;
      check_idle("midline_reset");
      @(posedge vga_clk); @(posedge vga_clk); #3;
      rst_n = 1'b1;
      model_reset();
      tick(0, 1, 0);
      gap(2);
      for (int k = 0; k < 20; k++) begin
         tick(1, 0, 0);
         tests++;
         if (fb_rd_addr !== 17'(k / 2)) begin
            fails++; $display("FAIL restart_addr k=%0d got %0d want %0d", k, fb_rd_addr, k / 2);
         end
      end
      gap(5);
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         tick(0, 1, ($urandom_range(0, 1) == 1));
         gap(int'($urandom_range(1, 4)));
         for (int l = 0; l < 20; l++) begin
            int n;
            n = int'($urandom_range(1, 660));
            for (int i = 0; i < n; i++) tick(1, 0, ($urandom_range(0, 49) == 0));
            for (int i = 0; i < int'($urandom_range(1, 5)); i++)
               tick(0, 0, ($urandom_range(0, 9) == 0));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 76800; i++) mem[i] = 12'($urandom_range(1, 4095));
      model_reset();
      test_reset();
      test_first_line();
      test_full_frame();
      test_swap();
      test_swap_same_cycle();
      test_reset_midline();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
